// File: rtl/inst_mem_resp.sv
// Instruction memory with a registered IDLE/WAIT/RESP response FSM and WAIT_CYCLES extra latency.
// Define INST_MEM_ALIGN_CHECK_EN to return a NOP for fetches with addr[1:0] != 0.
module inst_mem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall_req
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 2'd0 : 2'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  mis_q, mis_d;
  logic [31:0]           inst_q;
  logic                  valid_q;
  logic                  stall_q, stall_d;

  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_mis;

  logic [DEPTH_LOG2-1:0] addr_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  addr_mis;

  logic [31:0]           mem [DEPTH];

  assign addr_idx = addr[DEPTH_LOG2+1:2];
  assign wr_idx   = wr_addr[DEPTH_LOG2+1:2];

`ifdef INST_MEM_ALIGN_CHECK_EN
  assign addr_mis = |addr[1:0];
`else
  assign addr_mis = 1'b0;
`endif

  // Upper address bits alias onto the array; byte-offset bits are only
  // meaningful when the alignment check is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0],
                              wr_addr[31:DEPTH_LOG2+2], wr_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    stall_d = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    rd_mis  = mis_q;

    if (!ce) begin
      // Dropping the fetch enable aborts any pending request without a response.
      state_d = IDLE;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        IDLE, RESP: begin
          idx_d = addr_idx;
          mis_d = addr_mis;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            rd_en   = 1'b1;
            rd_idx  = addr_idx;
            rd_mis  = addr_mis;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
            stall_d = 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            cnt_d   = cnt_q - 2'd1;
            stall_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      valid_q <= rd_en;
      stall_q <= stall_d;
      inst_q  <= (rd_en && !rd_mis) ? mem[rd_idx] : 32'h0;
    end
  end

  // Array is not cleared by reset; a read on the same edge as a write sees the old word.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign stall_req  = stall_q;

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: WAIT_CYCLES=0 and WAIT_CYCLES=2 instances share stimulus and a request-level model.
module tb_inst_mem_resp;

  localparam int DL   = 10;
  localparam int MASK = (1 << DL) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, wr_en;
  logic [31:0] addr, wr_addr, wr_data;
  logic [31:0] inst0, inst2;
  logic        val0, val2, st0, st2;

  inst_mem_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .inst(inst0), .inst_valid(val0), .stall_req(st0)
  );

  inst_mem_resp #(.DEPTH_LOG2(DL), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .inst(inst2), .inst_valid(val2), .stall_req(st2)
  );

  int checks = 0;
  int errors = 0;

  // Request-level model: one pending fetch per instance, counting down remaining wait cycles.
  logic [31:0] m_mem [1 << DL];
  bit          m_pend [2];
  int          m_rem  [2];
  int          m_pidx [2];
  bit          m_pmis [2];
  logic [31:0] e_inst [2];
  bit          e_val  [2];
  bit          e_stall[2];

  function automatic bit misaligned(input logic [31:0] a);
`ifdef INST_MEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  aidx;
    bit  amis;
    aidx = int'(addr >> 2) & MASK;
    amis = misaligned(addr);
    for (int k = 0; k < 2; k++) begin
      int w;
      w = (k == 0) ? 0 : 2;
      if (!rst || !ce) begin
        m_pend[k] = 1'b0;
        e_inst[k] = 32'h0; e_val[k] = 1'b0; e_stall[k] = 1'b0;
      end else if (m_pend[k]) begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_pend[k]  = 1'b0;
          e_val[k]   = 1'b1;
          e_inst[k]  = m_pmis[k] ? 32'h0 : m_mem[m_pidx[k]];
          e_stall[k] = 1'b0;
        end else begin
          e_val[k] = 1'b0; e_inst[k] = 32'h0; e_stall[k] = 1'b1;
        end
      end else if (w == 0) begin
        e_val[k]   = 1'b1;
        e_inst[k]  = amis ? 32'h0 : m_mem[aidx];
        e_stall[k] = 1'b0;
      end else begin
        m_pend[k] = 1'b1; m_rem[k] = w; m_pidx[k] = aidx; m_pmis[k] = amis;
        e_val[k] = 1'b0; e_inst[k] = 32'h0; e_stall[k] = 1'b1;
      end
    end
    if (rst && wr_en) m_mem[int'(wr_addr >> 2) & MASK] = wr_data;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("w0_inst",  inst0, e_inst[0]);
    chk("w0_valid", {31'b0, val0}, {31'b0, e_val[0]});
    chk("w0_stall", {31'b0, st0},  {31'b0, e_stall[0]});
    chk("w2_inst",  inst2, e_inst[1]);
    chk("w2_valid", {31'b0, val2}, {31'b0, e_val[1]});
    chk("w2_stall", {31'b0, st2},  {31'b0, e_stall[1]});
  endtask

  typedef struct {
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] exp_inst;
    logic        exp_val;
    logic        exp_stall;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic c, input logic [31:0] a,
                              input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [31:0] ei, input logic ev, input logic es);
    vec_t v;
    v.rst = r; v.ce = c; v.addr = a; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.exp_inst = ei; v.exp_val = ev; v.exp_stall = es;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    logic [31:0] mis_exp;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_rem[k] = 0; m_pidx[k] = 0; m_pmis[k] = 1'b0;
      e_inst[k] = 32'h0; e_val[k] = 1'b0; e_stall[k] = 1'b0;
    end
`ifdef INST_MEM_ALIGN_CHECK_EN
    mis_exp = 32'h0000_0000;
`else
    mis_exp = 32'h0000_0022;
`endif

    tbl[0]  = mk(0, 1, 32'h0,    1, 32'h14, 32'h0000_0BAD, 32'h0, 0, 0);
    tbl[1]  = mk(1, 0, 32'h0,    1, 32'h0,  32'h11, 32'h0, 0, 0);
    tbl[2]  = mk(1, 0, 32'h0,    1, 32'h4,  32'h22, 32'h0, 0, 0);
    tbl[3]  = mk(1, 0, 32'h0,    1, 32'h8,  32'h33, 32'h0, 0, 0);
    tbl[4]  = mk(1, 0, 32'h0,    1, 32'hC,  32'h44, 32'h0, 0, 0);
    tbl[5]  = mk(1, 1, 32'h0,    0, 32'h0,  32'h0,  32'h11, 1, 0);
    tbl[6]  = mk(1, 1, 32'h4,    0, 32'h0,  32'h0,  32'h22, 1, 0);
    tbl[7]  = mk(1, 1, 32'h8,    0, 32'h0,  32'h0,  32'h33, 1, 0);
    tbl[8]  = mk(1, 1, 32'hC,    0, 32'h0,  32'h0,  32'h44, 1, 0);
    tbl[9]  = mk(1, 1, 32'h6,    0, 32'h0,  32'h0,  mis_exp, 1, 0);
    tbl[10] = mk(1, 1, 32'h4,    1, 32'h4,  32'hDEAD_BEEF, 32'h22, 1, 0);
    tbl[11] = mk(1, 1, 32'h4,    0, 32'h0,  32'h0,  32'hDEAD_BEEF, 1, 0);
    tbl[12] = mk(1, 0, 32'h4,    0, 32'h0,  32'h0,  32'h0, 0, 0);
    tbl[13] = mk(1, 1, 32'h1008, 0, 32'h0,  32'h0,  32'h33, 1, 0);

    rst = 1'b0; ce = 1'b0; addr = 32'h0; wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    step();

    // Preload the words used by the random phase.
    rst = 1'b1; wr_en = 1'b1;
    for (int i = 4; i < 16; i++) begin
      wr_addr = 32'(i * 4);
      wr_data = $urandom;
      step();
    end
    wr_en = 1'b0;

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; ce = tbl[i].ce; addr = tbl[i].addr;
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      step();
      chk($sformatf("tbl%0d_inst", i),  inst0, tbl[i].exp_inst);
      chk($sformatf("tbl%0d_valid", i), {31'b0, val0}, {31'b0, tbl[i].exp_val});
      chk($sformatf("tbl%0d_stall", i), {31'b0, st0},  {31'b0, tbl[i].exp_stall});
    end

    // Restore word 1 and go idle.
    rst = 1'b1; ce = 1'b0; wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h22;
    step();
    wr_en = 1'b0;

    // Two-cycle wait, address change during WAIT ignored.
    ce = 1'b1; addr = 32'h8;
    step();
    chk("wait_stall1", {31'b0, st2}, 32'd1);
    chk("wait_valid1", {31'b0, val2}, 32'd0);
    addr = 32'h0;
    step();
    chk("wait_stall2", {31'b0, st2}, 32'd1);
    step();
    chk("wait_inst",  inst2, 32'h33);
    chk("wait_valid", {31'b0, val2}, 32'd1);
    chk("wait_stall3", {31'b0, st2}, 32'd0);

    // Abort in the second WAIT cycle.
    ce = 1'b0;
    step();
    ce = 1'b1; addr = 32'h8;
    step();
    step();
    ce = 1'b0;
    step();
    chk("abort_stall", {31'b0, st2}, 32'd0);
    chk("abort_valid", {31'b0, val2}, 32'd0);
    chk("abort_inst",  inst2, 32'h0);
    step();
    chk("abort_late_valid", {31'b0, val2}, 32'd0);

    // Reset mid-WAIT, array preserved.
    ce = 1'b1; addr = 32'h8;
    step();
    rst = 1'b0;
    step();
    chk("rst_stall", {31'b0, st2}, 32'd0);
    chk("rst_valid", {31'b0, val2}, 32'd0);
    chk("rst_inst",  inst2, 32'h0);
    rst = 1'b1; addr = 32'h4;
    step();
    chk("rst_w0_inst", inst0, 32'h22);
    step();
    step();
    chk("rst_w2_inst",  inst2, 32'h22);
    chk("rst_w2_valid", {31'b0, val2}, 32'd1);
    ce = 1'b0;
    step();

    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(63) != 0);
      ce      = ($urandom_range(7) != 0);
      addr    = {$urandom_range(15, 0) == 0 ? 20'($urandom) : 20'h0,
                 6'b0, 4'($urandom_range(15)), 2'($urandom_range(3))};
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = {20'($urandom), 6'b0, 4'($urandom_range(15)), 2'($urandom_range(3))};
      wr_data = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_resp.md
INST_MEM_RESP -- requirements
Module: inst_mem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set the word-array depth to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 0, legal 0..3, SHALL set the extra wait cycles inserted before each response.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge).
REQ-005 ce  input  1  fetch request/chip enable from the PC stage; 1 = fetch addr.
REQ-006 addr  input  32  byte fetch address; word index = addr[DEPTH_LOG2+1:2]; upper bits ignored.
REQ-007 wr_en  input  1  load-port write strobe (boot loader/bench).
REQ-008 wr_addr  input  32  load-port byte address; word index taken as for addr.
REQ-009 wr_data  input  32  load-port write word.
REQ-010 inst  output  32  fetched instruction word; 0 when not valid.
REQ-011 inst_valid  output  1  inst holds the response for the most recently accepted request.
REQ-012 stall_req  output  1  PC stage SHALL hold addr while high.

Function
REQ-013 States: IDLE, WAIT, RESP; state, inst, inst_valid and stall_req SHALL all be registered.
REQ-014 Accept: in IDLE or RESP with ce=1, addr SHALL be captured. With WAIT_CYCLES=0, the next state SHALL be RESP; otherwise the next state SHALL be WAIT with the wait counter loaded to WAIT_CYCLES-1.
REQ-015 WAIT: the counter SHALL decrement each cycle; when it is 0 the next state SHALL be RESP. addr changes during WAIT SHALL be ignored.
REQ-016 Latency: a request accepted at edge N SHALL produce inst_valid=1 with the word data at edge N+1+WAIT_CYCLES, held for exactly one cycle per request.
REQ-017 WAIT_CYCLES=0 SHALL sustain one accepted request per cycle (back-to-back RESP), with stall_req constantly 0.
REQ-018 stall_req SHALL be 1 for exactly the cycles the block is in WAIT, and 0 otherwise.
REQ-019 Memory read SHALL occur on the edge entering RESP. A same-edge wr_en to the same word SHALL return the old data; a write on an earlier edge SHALL be visible.
REQ-020 ce=0 in any state SHALL force the next state to IDLE, with inst=0 and inst_valid=0; a pending WAIT request SHALL be aborted with no response.
REQ-021 RESP with ce=0 SHALL return to IDLE; RESP with ce=1 SHALL accept the new request per REQ-014.
REQ-022 Writes SHALL complete in one cycle, independent of state and ce.
REQ-023 Word index SHALL wrap modulo 2**DEPTH_LOG2 (address aliasing, no error).

Reset
REQ-024 rst=0 SHALL set state=IDLE, wait counter=0, inst=0, inst_valid=0 and stall_req=0 at the next edge, including mid-WAIT (the request is dropped).
REQ-025 The word array SHALL NOT be cleared by reset, and wr_en SHALL be ignored while rst=0.
REQ-026 The first request SHALL be accepted on the first edge with rst=1 and ce=1.

Configuration
REQ-027 Macro INST_MEM_ALIGN_CHECK_EN: when defined, a request with addr[1:0]!=0 SHALL follow normal timing but return inst=32'h00000000 (NOP) with inst_valid=1.
REQ-028 Without INST_MEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored and the aligned word returned.

Verification
REQ-029 WAIT_CYCLES=0; load words 0..3 = 11,22,33,44 (hex); ce=1 with addr 0,4,8,C on successive edges -> inst 11,22,33,44 on the 4 following edges; inst_valid=1 throughout; stall_req=0.
REQ-030 WAIT_CYCLES=2; request addr=8 -> stall_req=1 for 2 cycles, then inst=33, inst_valid=1 at edge N+3; an addr change to 0 during WAIT is ignored.
REQ-031 WAIT_CYCLES=2; drop ce to 0 in the second WAIT cycle -> no response; state=IDLE; inst=0; stall_req=0 next cycle.
REQ-032 rst=0 asserted mid-WAIT -> all outputs 0 next edge; after release, addr=4 returns 22 (array preserved).
REQ-033 Same-edge write of DEADBEEF to word 1 as the RESP-entry read of addr=4 -> 22 returned; a re-read returns DEADBEEF.
REQ-034 With INST_MEM_ALIGN_CHECK_EN, addr=6 -> inst=00000000, inst_valid=1. Without it -> inst=22.
